data_mem_requester: RTL and testbench
=====================================

// Module: data_mem_requester
// PURPOSE
//   Initiator side of the data-memory port. Takes load/store requests from the MEM stage and
//   sequences mem_read/mem_write, address and write_data into the data memory. Loads return
//   extracted and extended lanes; sub-doubleword stores use read-modify-write.
//   Sits between the execute/MEM pipeline logic and the data memory block.
// PARAMETERS
//   WORD         64  data and address width in bits; fixed doubleword memory lane
//   MEM_LATENCY  1   cycles from mem_read high to valid read_data; legal range 1..15
// PORTS
//   clk          in   1     single clock; all state changes on the rising edge
//   reset_n      in   1     asynchronous, active-low reset
//   req_valid    in   1     request present
//   req_ready    out  1     unit can accept a request; high only in IDLE
//   req_store    in   1     1 = store (STUR*), 0 = load (LDUR*)
//   req_size     in   2     access size: 0 = byte, 1 = half, 2 = word, 3 = doubleword
//   req_signed   in   1     load sign-extends (LDURSW); ignored for stores
//   req_addr     in   WORD  byte address
//   req_wdata    in   WORD  store data; low 8/16/32/64 bits are used
//   resp_valid   out  1     response present
//   resp_ready   in   1     consumer takes the response
//   resp_data    out  WORD  load result; 0 for stores and for errors
//   resp_err     out  1     misaligned access; no memory cycle was issued
//   mem_address  out  WORD  doubleword-aligned address, req_addr with bits [2:0] = 0
//   mem_write_data out WORD full doubleword written on mem_write
//   mem_read     out  1     read strobe
//   mem_write    out  1     write strobe
//   mem_read_data in  WORD  memory read data; valid MEM_LATENCY cycles after mem_read rises
// BEHAVIOUR
//   States: IDLE, RD_WAIT, WR, RESP.
//   Reset (async): state goes to IDLE. resp_valid, resp_err, mem_read and mem_write go to 0.
//     resp_data, mem_address and mem_write_data also go to 0.
//   Reset mid-operation aborts at once. mem_write drops without waiting for the clock, so no
//     partial write and no response is produced.
//   Accept: req_valid && req_ready at edge T latches store, size, signed, addr and wdata.
//     Input changes after T are ignored until the next acceptance.
//   Alignment check: misaligned when addr mod (1 << size) != 0.
//     A misaligned request goes to RESP at T+1 with resp_err = 1 and resp_data = 0.
//     mem_read and mem_write both stay 0.
//   Load: IDLE -> RD_WAIT. mem_read = 1 from T+1 for exactly MEM_LATENCY cycles.
//     mem_read_data is sampled on the last of those cycles.
//     Lane = data >> (8 * addr[2:0]), truncated to the access size.
//     The lane is zero-extended, or sign-extended when req_signed = 1. Doubleword is passed through.
//     The unit enters RESP so resp_valid rises at T + MEM_LATENCY + 1.
//   Doubleword store: IDLE -> WR. mem_write = 1 for exactly one cycle (T+1) with
//     mem_write_data = wdata. Then RESP, so resp_valid rises at T+2.
//   Sub-doubleword store: IDLE -> RD_WAIT (same read as a load), then WR for one cycle.
//     The write data is the read doubleword with the addressed lane replaced by the low wdata bits.
//     Then RESP; resp_valid rises at T + MEM_LATENCY + 2.
//   Memory strobes: mem_read and mem_write are never high together.
//     mem_address is stable for the whole RD_WAIT -> WR sequence.
//   RESP: resp_valid = 1 and resp_data/resp_err are held until resp_ready = 1 at an edge.
//     The state then returns to IDLE and resp_valid = 0 on the next cycle.
//   Throughput: no new request is accepted while RESP is stalled.
//     Back-to-back requests cost one IDLE cycle each.
//   Boundaries: a byte access accepts any addr[2:0]. A half access at addr[2:0] = 7 is misaligned.
//     Addresses near 2^WORD wrap naturally; no carry into the alignment logic.
// TESTING
//   LDUR doubleword, addr 0x18, memory holds 0x1122334455667788
//     -> mem_read for MEM_LATENCY cycles, mem_address 0x18, resp_data 0x1122334455667788.
//   LDURB addr 0x1B on the same word -> resp_data 0x0000000000000055.
//   LDURSW addr 0x1C, upper word 0x80000001 -> resp_data 0xFFFFFFFF80000001.
//   STURH addr 0x1A, wdata 0xBEEF -> one read, then one mem_write of 0x11223344BEEF7788.
//     resp_err = 0.
//   Misaligned LDUR at addr 0x1C -> no mem_read/mem_write, resp_err = 1, resp_data = 0 at T+1.
//   STUR with resp_ready held 0 for 5 cycles, reset_n pulsed low during the following WR
//     -> response held for 5 cycles; on reset mem_write falls at once and outputs return to 0.

Source files
------------

// File: rtl/data_mem_requester.sv
// Load/store sequencer for the doubleword data memory; sub-doubleword stores read-modify-write.
// Load L+1, dword store 2, sub-dword store L+2, misaligned 1 cycle to resp_valid; no accept while a response is pending.
module data_mem_requester #(
  parameter int WORD        = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_data,
  output logic            resp_err,
  output logic [WORD-1:0] mem_address,
  output logic [WORD-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [WORD-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  typedef struct packed {
    logic            store;
    logic [1:0]      size;
    logic            sgn;
    logic [2:0]      addr_lo;
    logic [WORD-1:0] wdata;
  } req_t;

  localparam logic [3:0] LAST_RD = 4'(MEM_LATENCY - 1);

  state_t          state_q, state_d;
  req_t            req_q;
  logic [3:0]      cnt_q;
  logic            accept, misaligned, rd_last;
  logic [2:0]      align_mask;
  logic [5:0]      shamt;
  logic [WORD-1:0] lane, load_val, size_mask, merged;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == RD_WAIT);
  // Combinational from state so an async reset drops the strobe immediately.
  assign mem_write  = (state_q == WR);

  assign accept  = req_valid && req_ready;
  assign rd_last = (state_q == RD_WAIT) && (cnt_q == LAST_RD);
  assign shamt   = {req_q.addr_lo, 3'b000};

  always_comb begin
    align_mask = 3'b000;
    case (req_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    misaligned = |(req_addr[2:0] & align_mask);
  end

  always_comb begin
    lane      = mem_read_data >> shamt;
    load_val  = lane;
    size_mask = '1;
    case (req_q.size)
      2'd0: begin
        size_mask = {{(WORD-8){1'b0}}, 8'hFF};
        load_val  = {{(WORD-8){req_q.sgn & lane[7]}}, lane[7:0]};
      end
      2'd1: begin
        size_mask = {{(WORD-16){1'b0}}, 16'hFFFF};
        load_val  = {{(WORD-16){req_q.sgn & lane[15]}}, lane[15:0]};
      end
      2'd2: begin
        size_mask = {{(WORD-32){1'b0}}, 32'hFFFF_FFFF};
        load_val  = {{(WORD-32){req_q.sgn & lane[31]}}, lane[31:0]};
      end
      default: begin
        size_mask = '1;
        load_val  = lane;
      end
    endcase
    merged = (mem_read_data & ~(size_mask << shamt)) | ((req_q.wdata & size_mask) << shamt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned)                          state_d = RESP;
          else if (req_store && req_size == 2'd3)  state_d = WR;
          else                                     state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (rd_last) state_d = req_q.store ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q          <= '0;
      cnt_q          <= '0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      if (accept) begin
        req_q          <= '{store: req_store, size: req_size, sgn: req_signed,
                            addr_lo: req_addr[2:0], wdata: req_wdata};
        cnt_q          <= '0;
        mem_address    <= {req_addr[WORD-1:3], 3'b000};
        mem_write_data <= req_wdata;
        resp_data      <= '0;
        resp_err       <= misaligned;
      end
      if (state_q == RD_WAIT) begin
        cnt_q <= cnt_q + 4'd1;
        if (rd_last) begin
          if (req_q.store) mem_write_data <= merged;
          else             resp_data      <= load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_requester.sv
// Directed bench for data_mem_requester with a latency-exact memory model and strobe monitor.
module tb_data_mem_requester;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [63:0] resp_data, mem_address, mem_write_data, mem_read_data;

  logic [63:0] mem [8];
  logic        tb_wr_en = 1'b0;
  logic [2:0]  tb_wr_idx = '0;
  logic [63:0] tb_wr_dat = '0;
  int          rd_run = 0;

  int          n_checks = 0, n_fail = 0;
  int          rd_cnt, wr_cnt, both_cnt = 0, addr_glitch = 0;
  logic        strobe_seen;
  logic [63:0] strobe_addr, wdata_seen;

  always #5 clk = ~clk;

  data_mem_requester #(.WORD(64), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  // Data is only valid on the last cycle of the read strobe.
  assign mem_read_data = (mem_read && rd_run == LAT - 1) ? mem[mem_address[5:3]] : 64'hDEAD_DEAD_DEAD_DEAD;

  always @(posedge clk) begin
    rd_run <= mem_read ? rd_run + 1 : 0;
    if (mem_write)     mem[mem_address[5:3]] <= mem_write_data;
    else if (tb_wr_en) mem[tb_wr_idx]        <= tb_wr_dat;
  end

  always @(negedge clk) begin
    if (mem_read)  rd_cnt++;
    if (mem_write) begin wr_cnt++; wdata_seen = mem_write_data; end
    if (mem_read && mem_write) both_cnt++;
    if (mem_read || mem_write) begin
      if (strobe_seen && mem_address !== strobe_addr) addr_glitch++;
      strobe_addr = mem_address;
      strobe_seen = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke_mem(input logic [2:0] idx, input logic [63:0] dat);
    @(negedge clk);
    tb_wr_en = 1'b1; tb_wr_idx = idx; tb_wr_dat = dat;
    @(posedge clk); #1 tb_wr_en = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd, input int exp_cyc,
                         input logic [63:0] exp_data, input logic exp_err, input int exp_rd,
                         input int exp_wr, input logic [63:0] exp_wdata, input int stall);
    int cyc;
    @(negedge clk);
    check_eq({tag, " req_ready"}, req_ready, 1'b1);
    rd_cnt = 0; wr_cnt = 0; strobe_seen = 1'b0;
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = ~st; req_size = ~sz; req_signed = ~sg; req_addr = ~a; req_wdata = ~wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 40);
    check_eq({tag, " resp_valid"}, resp_valid, 1'b1);
    check_eq({tag, " latency"}, cyc, exp_cyc);
    check_eq({tag, " resp_data"}, resp_data, exp_data);
    check_eq({tag, " resp_err"}, resp_err, exp_err);
    check_eq({tag, " reads"}, rd_cnt, exp_rd);
    check_eq({tag, " writes"}, wr_cnt, exp_wr);
    if (exp_rd + exp_wr > 0) check_eq({tag, " mem_address"}, strobe_addr, {a[63:3], 3'b000});
    if (exp_wr > 0) check_eq({tag, " write_data"}, wdata_seen, exp_wdata);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq({tag, " held valid"}, resp_valid, 1'b1);
      check_eq({tag, " held data"}, {resp_err, resp_data[62:0]}, {exp_err, exp_data[62:0]});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    check_eq({tag, " valid drop"}, resp_valid, 1'b0);
    check_eq({tag, " back idle"}, req_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 64'h5555_5555_5555_5555;
    mem[3] = 64'h1122_3344_5566_7788;
    #12;
    check_eq("rst req_ready", req_ready, 1'b1);
    check_eq("rst resp", {resp_valid, resp_err, mem_read, mem_write}, 4'b0000);
    check_eq("rst resp_data", resp_data, 64'h0);
    check_eq("rst mem_address", mem_address, 64'h0);
    check_eq("rst mem_write_data", mem_write_data, 64'h0);
    @(negedge clk); reset_n = 1'b1;

    //      tag          st  sz  sg  addr     wdata                  cyc    data                   err  rd   wr  wdata                  stall
    run_req("ldur",      0, 3, 0, 64'h18, 64'h0,                 LAT+1, 64'h1122334455667788, 0, LAT, 0, 64'h0,                 0);
    run_req("ldurb",     0, 0, 0, 64'h1B, 64'h0,                 LAT+1, 64'h0000000000000055, 0, LAT, 0, 64'h0,                 0);
    run_req("sturh",     1, 1, 0, 64'h1A, 64'hFFFF_0000_1234_BEEF, LAT+2, 64'h0,              0, LAT, 1, 64'h11223344BEEF7788, 0);
    run_req("ldur rb",   0, 3, 0, 64'h18, 64'h0,                 LAT+1, 64'h11223344BEEF7788, 0, LAT, 0, 64'h0,                 0);
    poke_mem(3'd3, 64'h8000_0001_BEEF_7788);
    run_req("ldursw",    0, 2, 1, 64'h1C, 64'h0,                 LAT+1, 64'hFFFFFFFF80000001, 0, LAT, 0, 64'h0,                 0);
    run_req("ldurw",     0, 2, 0, 64'h1C, 64'h0,                 LAT+1, 64'h0000000080000001, 0, LAT, 0, 64'h0,                 0);
    run_req("ldursh",    0, 1, 1, 64'h1E, 64'h0,                 LAT+1, 64'hFFFFFFFFFFFF8000, 0, LAT, 0, 64'h0,                 0);
    run_req("ldursb 7",  0, 0, 1, 64'h1F, 64'h0,                 LAT+1, 64'hFFFFFFFFFFFFFF80, 0, LAT, 0, 64'h0,                 0);
    run_req("mis ldur",  0, 3, 0, 64'h1C, 64'h0,                 1,     64'h0,                1, 0,   0, 64'h0,                 0);
    run_req("mis half7", 0, 1, 1, 64'h1F, 64'h0,                 1,     64'h0,                1, 0,   0, 64'h0,                 0);
    run_req("mis stw",   1, 2, 0, 64'h1A, 64'h1234,              1,     64'h0,                1, 0,   0, 64'h0,                 0);
    run_req("sturb 7",   1, 0, 0, 64'h1F, 64'h0000_0000_0000_01AB, LAT+2, 64'h0,              0, LAT, 1, 64'hAB000001BEEF7788, 0);
    run_req("ldur top",  0, 3, 0, 64'hFFFF_FFFF_FFFF_FFD8, 64'h0, LAT+1, 64'hAB000001BEEF7788, 0, LAT, 0, 64'h0,                 0);
    run_req("stur stall",1, 3, 0, 64'h20, 64'hCAFE_F00D_1234_5678, 2,   64'h0,                0, 0,   1, 64'hCAFEF00D12345678, 5);

    // Store whose write cycle is cut by an asynchronous reset.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd3; req_addr = 64'h28; req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(posedge clk); #1 req_valid = 1'b0;
    #1 check_eq("rst wr strobe", mem_write, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("rst wr drop", mem_write, 1'b0);
    check_eq("rst wr flags", {resp_valid, resp_err, mem_read}, 3'b000);
    check_eq("rst wr addr", mem_address, 64'h0);
    check_eq("rst wr wdata", mem_write_data, 64'h0);
    check_eq("rst wr ready", req_ready, 1'b1);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst no write", mem[5], 64'h5555_5555_5555_5555);
    check_eq("rst no resp", resp_valid, 1'b0);

    run_req("ldur after",0, 3, 0, 64'h20, 64'h0,                 LAT+1, 64'hCAFEF00D12345678, 0, LAT, 0, 64'h0,                 0);
    check_eq("strobe overlap", both_cnt, 0);
    check_eq("address stable", addr_glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
